// File: rtl/soft_rst_pkg.sv
// Shared definitions for the soft-reset requester: FSM states, register map,
// CAUSE bit positions and the default command key.
package soft_rst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_REQ   = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } soft_rst_state_e;

  // Word offsets, decoded from paddr[3:2]
  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_DELAY = 2'd1;
  localparam logic [1:0] ADDR_CAUSE = 2'd2;
  localparam logic [1:0] ADDR_WDT   = 2'd3;

  localparam int CAUSE_CORE = 0;
  localparam int CAUSE_SYS  = 1;
  localparam int CAUSE_WDT  = 2;
  localparam int CAUSE_POR  = 3;

  localparam logic [3:0] CAUSE_RESET     = 4'b1000;
  localparam logic [7:0] RST_KEY_DEFAULT = 8'h5A;

endpackage

// File: rtl/soft_rst_wdt.sv
// Watchdog counter for the soft-reset requester (built only with SOFT_RST_WDT_EN).
// A keyed write loads enable/reload and restarts the count; expiry pulses for one cycle.
module soft_rst_wdt
  import soft_rst_pkg::*;
(
  input  logic        sys_clk,
  input  logic        mcu_rst_signal,
  input  logic        i_wr,
  input  logic [31:0] i_wdata,
  output logic        o_expire,
  output logic [31:0] o_rdata
);

  logic        r_en;
  logic [15:0] r_reload;
  logic [15:0] r_cnt;
  logic        w_unused;

  assign w_unused = ^i_wdata[30:16];
  assign o_expire = r_en && (r_cnt == 16'd0);
  assign o_rdata  = {r_en, 15'd0, r_reload};

  // Expiry always reloads; the requester decides whether to act on the pulse.
  always_ff @(posedge sys_clk or negedge mcu_rst_signal) begin
    if (!mcu_rst_signal) begin
      r_en     <= 1'b0;
      r_reload <= 16'd0;
      r_cnt    <= 16'd0;
    end else if (i_wr) begin
      r_en     <= i_wdata[31];
      r_reload <= i_wdata[15:0];
      r_cnt    <= i_wdata[15:0];
    end else if (r_en) begin
      r_cnt <= (r_cnt == 16'd0) ? r_reload : r_cnt - 16'd1;
    end
  end

endmodule

// File: rtl/soft_rst_req_ctrl.sv
// APB soft-reset requester: keyed, delayed core/system reset requests held until
// the reset controller acknowledges. Optional watchdog at 0xC via SOFT_RST_WDT_EN.
module soft_rst_req_ctrl
  import soft_rst_pkg::*;
#(
  parameter int         PULSE_CYCLES = 16,
  parameter logic [7:0] RST_KEY      = RST_KEY_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        mcu_rst_signal,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic        pad_cpu_rst_b,
  input  logic        sys_resetn,
  output logic [1:0]  cpu_pad_soft_rst,
  output logic [2:0]  o_dbg_state
);

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);

  soft_rst_state_e r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [7:0]  r_pcnt, w_pcnt_nxt;
  logic [1:0]  r_req, w_req_nxt;
  logic        r_wdt_src, w_wdt_src_nxt;
  logic [1:0]  r_soft_rst, w_soft_rst_nxt;
  logic [7:0]  r_delay;
  logic [3:0]  r_cause;
  logic [3:0]  w_cause_set;
  logic [3:0]  w_cause_clr;

  logic        w_wr, w_key_ok, w_ctrl_err, w_ctrl_go, w_ack;
  logic [1:0]  w_sel;
  logic        w_wdt_expire, w_wdt_err;
  logic [31:0] w_wdt_rdata;
  logic        w_unused;

  assign w_wr     = psel && penable && pwrite;
  assign w_sel    = paddr[3:2];
  assign w_key_ok = (pwdata[15:8] == RST_KEY);

  assign w_ctrl_err = w_wr && (w_sel == ADDR_CTRL) &&
                      (!w_key_ok || (pwdata[1:0] == 2'b00) || (r_state != ST_IDLE));
  assign w_ctrl_go  = w_wr && (w_sel == ADDR_CTRL) && !w_ctrl_err;

`ifdef SOFT_RST_WDT_EN
  logic w_wdt_wr;
  assign w_wdt_wr  = w_wr && (w_sel == ADDR_WDT) && w_key_ok;
  assign w_wdt_err = w_wr && (w_sel == ADDR_WDT) && !w_key_ok;
  assign w_unused  = ^paddr[1:0];

  soft_rst_wdt u_wdt (
    .sys_clk        (sys_clk),
    .mcu_rst_signal (mcu_rst_signal),
    .i_wr           (w_wdt_wr),
    .i_wdata        (pwdata),
    .o_expire       (w_wdt_expire),
    .o_rdata        (w_wdt_rdata)
  );
`else
  assign w_wdt_expire = 1'b0;
  assign w_wdt_err    = 1'b0;
  assign w_wdt_rdata  = 32'd0;
  assign w_unused     = ^{paddr[1:0], pwdata[31:16]};
`endif

  assign pready           = 1'b1;
  assign pslverr          = w_ctrl_err || w_wdt_err;
  assign cpu_pad_soft_rst = r_soft_rst;
  assign o_dbg_state      = r_state;

  // System request takes ack priority when both bits are set.
  assign w_ack       = r_req[1] ? !sys_resetn : !pad_cpu_rst_b;
  assign w_cause_clr = (w_wr && (w_sel == ADDR_CAUSE)) ? pwdata[3:0] : 4'h0;

  always_comb begin
    prdata = 32'd0;
    if (psel && !pwrite) begin
      case (w_sel)
        ADDR_DELAY: prdata = {24'd0, r_delay};
        ADDR_CAUSE: prdata = {28'd0, r_cause};
        ADDR_WDT:   prdata = w_wdt_rdata;
        default:    prdata = 32'd0;
      endcase
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pcnt_nxt    = r_pcnt;
    w_req_nxt     = r_req;
    w_wdt_src_nxt = r_wdt_src;
    w_cause_set   = 4'h0;
    case (r_state)
      ST_IDLE: begin
        if (w_ctrl_go) begin
          w_state_nxt   = ST_COUNT;
          w_req_nxt     = pwdata[1:0];
          w_cnt_nxt     = r_delay;
          w_wdt_src_nxt = 1'b0;
        end
      end
      ST_COUNT: begin
        if (r_cnt == 8'd0) w_state_nxt = ST_REQ;
        else               w_cnt_nxt   = r_cnt - 8'd1;
      end
      ST_REQ: begin
        if (w_ack) begin
          w_state_nxt = ST_HOLD;
          w_pcnt_nxt  = PULSE_LOAD;
          if (r_wdt_src)     w_cause_set[CAUSE_WDT]  = 1'b1;
          else if (r_req[1]) w_cause_set[CAUSE_SYS]  = 1'b1;
          else               w_cause_set[CAUSE_CORE] = 1'b1;
        end
      end
      ST_HOLD: begin
        if (r_pcnt == 8'd0) w_state_nxt = ST_DONE;
        else                w_pcnt_nxt  = r_pcnt - 8'd1;
      end
      ST_DONE: begin
        if (pad_cpu_rst_b && sys_resetn) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Watchdog expiry preempts a pending delay but never an active request.
    if (w_wdt_expire && ((r_state == ST_IDLE) || (r_state == ST_COUNT))) begin
      w_state_nxt   = ST_REQ;
      w_req_nxt     = 2'b10;
      w_cnt_nxt     = 8'd0;
      w_wdt_src_nxt = 1'b1;
    end
    w_soft_rst_nxt = ((w_state_nxt == ST_REQ) || (w_state_nxt == ST_HOLD)) ? w_req_nxt : 2'b00;
  end

  always_ff @(posedge sys_clk or negedge mcu_rst_signal) begin
    if (!mcu_rst_signal) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 8'd0;
      r_pcnt     <= 8'd0;
      r_req      <= 2'b00;
      r_wdt_src  <= 1'b0;
      r_soft_rst <= 2'b00;
      r_delay    <= 8'd0;
      r_cause    <= CAUSE_RESET;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pcnt     <= w_pcnt_nxt;
      r_req      <= w_req_nxt;
      r_wdt_src  <= w_wdt_src_nxt;
      r_soft_rst <= w_soft_rst_nxt;
      // A set in the same cycle as a software clear wins.
      r_cause    <= (r_cause & ~w_cause_clr) | w_cause_set;
      if (w_wr && (w_sel == ADDR_DELAY)) r_delay <= pwdata[7:0];
    end
  end

endmodule
